// File: rtl/fusion_psum_drain.sv
// Partial-sum drain at the bottom of a fusion-unit column: accumulates psum beats
// per lane (13/26/52-bit lanes) and streams the lane totals out one per cycle.
module fusion_psum_drain #(
  parameter int unsigned ACC_W = 64,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cfg_weight_width,
  input  logic             cfg_signed,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             psum_valid,
  output logic             psum_ready,
  input  logic [51:0]      psum_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PSUM_W  = 52;
  localparam int unsigned N_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t           state, state_n;
  // last_idx doubles as the lane-mode: 3 -> 13-bit lanes, 1 -> 26-bit, 0 -> 52-bit
  logic [1:0]       last_idx, last_idx_n;
  logic             sgn, sgn_n;
  logic [LEN_W-1:0] len, len_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [ACC_W-1:0] acc   [N_LANES];
  logic [ACC_W-1:0] acc_n [N_LANES];
  logic             out_valid_n, out_last_n, busy_n, done_n;
  logic [ACC_W-1:0] out_data_n;
  logic [1:0]       out_lane_n, lane_inc;

  // Extract lane k of a psum word for the given lane mode and extend it to ACC_W
  function automatic logic [ACC_W-1:0] lane_ext(input logic [PSUM_W-1:0] data,
                                                 input logic [1:0] mode,
                                                 input logic s,
                                                 input logic [1:0] k);
    logic [12:0] l13;
    logic [25:0] l26;
    lane_ext = '0;
    case (k)
      2'd0:    l13 = data[12:0];
      2'd1:    l13 = data[25:13];
      2'd2:    l13 = data[38:26];
      default: l13 = data[51:39];
    endcase
    l26 = k[0] ? data[51:26] : data[25:0];
    case (mode)
      2'd3: begin
        if (s) lane_ext = ACC_W'($signed(l13));
        else   lane_ext = ACC_W'(l13);
      end
      2'd1: begin
        if (s) lane_ext = ACC_W'($signed(l26));
        else   lane_ext = ACC_W'(l26);
      end
      default: begin
        if (s) lane_ext = ACC_W'($signed(data));
        else   lane_ext = ACC_W'(data);
      end
    endcase
  endfunction

  assign psum_ready = (state == ACCUM);

  always_comb begin
    state_n     = state;
    last_idx_n  = last_idx;
    sgn_n       = sgn;
    len_n       = len;
    cnt_n       = cnt;
    acc_n       = acc;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_lane_n  = out_lane;
    out_last_n  = out_last;
    done_n      = 1'b0;
    lane_inc    = out_lane + 2'd1;

    case (state)
      IDLE: begin
        if (start) begin
          case (cfg_weight_width)
            4'd2:    last_idx_n = 2'd3;
            4'd4:    last_idx_n = 2'd1;
            default: last_idx_n = 2'd0;
          endcase
          sgn_n = cfg_signed;
          len_n = cfg_len;
          cnt_n = '0;
          for (int unsigned k = 0; k < N_LANES; k++) acc_n[k] = '0;
          if (cfg_len == '0) begin
            state_n     = DRAIN;
            out_valid_n = 1'b1;
            out_data_n  = '0;
            out_lane_n  = 2'd0;
            out_last_n  = (last_idx_n == 2'd0);
          end else begin
            state_n = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (psum_valid) begin
          for (int unsigned k = 0; k < N_LANES; k++) begin
            if (2'(k) <= last_idx)
              acc_n[k] = acc[k] + lane_ext(psum_data, last_idx, sgn, 2'(k));
          end
          cnt_n = cnt + LEN_W'(1);
          // Final beat: present lane 0 totals (including this beat) on the next cycle
          if (cnt_n == len) begin
            state_n     = DRAIN;
            out_valid_n = 1'b1;
            out_data_n  = acc_n[0];
            out_lane_n  = 2'd0;
            out_last_n  = (last_idx == 2'd0);
          end
        end
      end

      DRAIN: begin
        if (out_ready) begin
          if (out_lane == last_idx) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
            out_data_n  = '0;
            out_lane_n  = 2'd0;
            out_last_n  = 1'b0;
            done_n      = 1'b1;
          end else begin
            out_data_n = acc[lane_inc];
            out_lane_n = lane_inc;
            out_last_n = (lane_inc == last_idx);
          end
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_idx  <= 2'd0;
      sgn       <= 1'b0;
      len       <= '0;
      cnt       <= '0;
      acc       <= '{default: '0};
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= 2'd0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      last_idx  <= last_idx_n;
      sgn       <= sgn_n;
      len       <= len_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_lane  <= out_lane_n;
      out_last  <= out_last_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_fusion_psum_drain.sv
// Self-checking bench for fusion_psum_drain: directed and randomized jobs checked
// against a lane-arithmetic reference model.
module tb_fusion_psum_drain;

  localparam int unsigned ACC_W = 64;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       cfg_weight_width = 4'd0;
  logic             cfg_signed = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             psum_valid = 1'b0;
  logic             psum_ready;
  logic [51:0]      psum_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic [1:0]       out_lane;
  logic             out_last;
  logic             busy;
  logic             done;

  fusion_psum_drain #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_weight_width(cfg_weight_width), .cfg_signed(cfg_signed), .cfg_len(cfg_len),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [51:0] beats[$];
  logic [63:0] got[4];
  logic        got_last[4];
  int          n_got, done_cyc;
  bit          lane_ok, stable_ok, ready_seen, busy_seen;

  function automatic int n_of(input logic [3:0] ww);
    if (ww == 4'd2) return 4;
    if (ww == 4'd4) return 2;
    return 1;
  endfunction

  // Total of lane k over all queued beats, using plain lane arithmetic mod 2^64
  function automatic logic [63:0] model(input logic [3:0] ww, input bit sgn, input int k);
    int L;
    logic [63:0] s;
    L = 52 / n_of(ww);
    s = 64'd0;
    foreach (beats[i]) begin
      logic [63:0] v;
      v = (64'(beats[i]) >> (k * L)) & ((64'd1 << L) - 64'd1);
      if (sgn && v[L-1]) v = v - (64'd1 << L);
      s = s + v;
    end
    return s;
  endfunction

  function automatic logic [51:0] rnd52();
    return {20'($urandom()), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from the queued beats and records what the drain side produced
  task automatic run_job(input logic [3:0] ww, input bit sgn, input int len, input bit gaps,
                         input int stall_lane, input int stall_n, input bit poke);
    int cyc, b, sc;
    bit tog, take, poked;
    logic [63:0] hd;
    logic [1:0]  hl;
    cyc = 0; b = 0; sc = 0; tog = 1'b1; poked = 1'b0; hd = '0; hl = '0;
    n_got = 0; done_cyc = -1; lane_ok = 1'b1; stable_ok = 1'b1; ready_seen = 1'b0;
    cfg_weight_width = ww; cfg_signed = sgn; cfg_len = LEN_W'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    busy_seen = busy;
    while (b < len && cyc < 300) begin
      start = 1'b0;
      if (poke && b == 1 && !poked) begin
        start = 1'b1; cfg_weight_width = 4'd8; cfg_len = LEN_W'(1); cfg_signed = !sgn;
        poked = 1'b1;
      end
      psum_valid = gaps ? tog : 1'b1;
      tog = !tog;
      psum_data = psum_valid ? beats[b] : rnd52();
      if (psum_ready) ready_seen = 1'b1;
      take = psum_valid && psum_ready;
      step(); cyc++;
      if (take) b++;
    end
    start = 1'b0;
    psum_valid = 1'b0;
    psum_data = rnd52();
    while (cyc < 300) begin
      if (psum_ready) ready_seen = 1'b1;
      out_ready = 1'b1;
      if (out_valid && int'(out_lane) == stall_lane && sc < stall_n) begin
        out_ready = 1'b0;
        if (sc > 0 && (out_data !== hd || out_lane !== hl)) stable_ok = 1'b0;
        hd = out_data; hl = out_lane; sc++;
      end else if (sc > 0 && out_valid && out_lane == hl && out_data !== hd) begin
        stable_ok = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (n_got < 4) begin
          got[n_got] = out_data;
          got_last[n_got] = out_last;
          if (out_lane !== 2'(n_got)) lane_ok = 1'b0;
        end
        n_got++;
      end
      step(); cyc++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cfg_weight_width = 4'd2; cfg_len = LEN_W'(3);
    step(); step();
    rst = 1'b0; start = 1'b0;
    checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL reset_psum_ready got %b exp 0", psum_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (out_lane !== 2'd0) begin errors++; $display("FAIL reset_out_lane got %0d exp 0", out_lane); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy got %b exp 0", busy); end
  endtask

  task automatic test_unsigned4();
    logic [63:0] exp_c[4];
    exp_c = '{64'd0, 64'd6, 64'd12, 64'd18};
    beats.delete();
    repeat (2) beats.push_back({13'd9, 13'd6, 13'd3, 13'd0});
    run_job(4'd2, 1'b0, 2, 1'b0, -1, 0, 1'b0);
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL u4_busy got %b exp 1", busy_seen); end
    checks++; if (n_got != 4) begin errors++; $display("FAIL u4_lanes got %0d exp 4", n_got); end
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL u4_done_latency got %0d exp 6", done_cyc); end
    checks++; if (!lane_ok) begin errors++; $display("FAIL u4_lane_index got bad exp 0..3"); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp_c[k] || got[k] !== model(4'd2, 1'b0, k)) begin
        errors++; $display("FAIL u4_lane%0d got %0d exp %0d", k, got[k], exp_c[k]);
      end
      checks++;
      if (got_last[k] !== (k == 3)) begin
        errors++; $display("FAIL u4_last%0d got %b exp %b", k, got_last[k], k == 3);
      end
    end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL u4_after_done done %b busy %b exp 0 0", done, busy); end
  endtask

  task automatic test_sign_ext();
    logic [63:0] exp0;
    for (int s = 0; s < 2; s++) begin
      beats.delete();
      repeat (3) beats.push_back({26'd24, 26'h3FFFFFF});
      run_job(4'd4, s[0], 3, 1'b0, -1, 0, 1'b0);
      exp0 = s[0] ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0000_0000_0BFF_FFFD;
      checks++; if (n_got != 2) begin errors++; $display("FAIL sx%0d_lanes got %0d exp 2", s, n_got); end
      checks++; if (got[0] !== exp0 || got[0] !== model(4'd4, s[0], 0)) begin errors++; $display("FAIL sx%0d_lane0 got %h exp %h", s, got[0], exp0); end
      checks++; if (got[1] !== 64'd72) begin errors++; $display("FAIL sx%0d_lane1 got %0d exp 72", s, got[1]); end
      checks++; if (got_last[1] !== 1'b1 || got_last[0] !== 1'b0) begin errors++; $display("FAIL sx%0d_last got %b%b exp 10", s, got_last[1], got_last[0]); end
      checks++; if (done_cyc != 5) begin errors++; $display("FAIL sx%0d_done_latency got %0d exp 5", s, done_cyc); end
    end
  endtask

  task automatic test_one_lane();
    logic [3:0] wws[2];
    wws = '{4'd8, 4'd3};
    foreach (wws[i]) begin
      beats.delete();
      repeat (4) beats.push_back(52'd65025);
      run_job(wws[i], 1'b1, 4, 1'b0, -1, 0, 1'b0);
      checks++; if (n_got != 1) begin errors++; $display("FAIL one_ww%0d_lanes got %0d exp 1", wws[i], n_got); end
      checks++; if (got[0] !== 64'd260100) begin errors++; $display("FAIL one_ww%0d_total got %0d exp 260100", wws[i], got[0]); end
      checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL one_ww%0d_last got %b exp 1", wws[i], got_last[0]); end
      checks++; if (done_cyc != 5) begin errors++; $display("FAIL one_ww%0d_done_latency got %0d exp 5", wws[i], done_cyc); end
    end
  endtask

  task automatic test_random();
    logic [3:0] ww;
    bit sgn;
    int len, n;
    for (int j = 0; j < 8; j++) begin
      case (j % 4)
        0: ww = 4'd2;
        1: ww = 4'd4;
        2: ww = 4'd8;
        default: ww = 4'($urandom_range(0, 15));
      endcase
      sgn = 1'($urandom());
      len = int'($urandom_range(1, 8));
      n = n_of(ww);
      beats.delete();
      for (int i = 0; i < len; i++) beats.push_back(rnd52());
      run_job(ww, sgn, len, 1'b0, -1, 0, 1'b0);
      checks++; if (n_got != n) begin errors++; $display("FAIL rnd%0d_lanes got %0d exp %0d", j, n_got, n); end
      checks++; if (done_cyc != len + n) begin errors++; $display("FAIL rnd%0d_done_latency got %0d exp %0d", j, done_cyc, len + n); end
      checks++; if (!lane_ok) begin errors++; $display("FAIL rnd%0d_lane_index got bad exp in order", j); end
      for (int k = 0; k < n && k < 4; k++) begin
        checks++;
        if (got[k] !== model(ww, sgn, k)) begin
          errors++; $display("FAIL rnd%0d_lane%0d got %h exp %h (ww %0d sgn %0d)", j, k, got[k], model(ww, sgn, k), ww, sgn);
        end
      end
    end
  endtask

  task automatic test_stall();
    beats.delete();
    for (int i = 0; i < 5; i++) beats.push_back(rnd52());
    run_job(4'd2, 1'b1, 5, 1'b1, 1, 3, 1'b0);
    checks++; if (n_got != 4) begin errors++; $display("FAIL stall_lanes got %0d exp 4", n_got); end
    checks++; if (!stable_ok) begin errors++; $display("FAIL stall_stable got unstable exp stable"); end
    checks++; if (!lane_ok) begin errors++; $display("FAIL stall_lane_index got bad exp in order"); end
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL stall_done got timeout exp pulse"); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== model(4'd2, 1'b1, k)) begin
        errors++; $display("FAIL stall_lane%0d got %h exp %h", k, got[k], model(4'd2, 1'b1, k));
      end
    end
  endtask

  task automatic test_zero_len();
    beats.delete();
    run_job(4'd2, 1'b0, 0, 1'b0, -1, 0, 1'b0);
    checks++; if (n_got != 4) begin errors++; $display("FAIL zero_lanes got %0d exp 4", n_got); end
    checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL zero_psum_ready got 1 exp 0"); end
    checks++; if (done_cyc != 4) begin errors++; $display("FAIL zero_done_latency got %0d exp 4", done_cyc); end
    checks++; if (got_last[3] !== 1'b1 || got_last[0] !== 1'b0) begin errors++; $display("FAIL zero_last got %b/%b exp 1/0", got_last[3], got_last[0]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== 64'd0) begin errors++; $display("FAIL zero_lane%0d got %h exp 0", k, got[k]); end
    end
  endtask

  task automatic test_ignored_start();
    beats.delete();
    for (int i = 0; i < 3; i++) beats.push_back(rnd52());
    run_job(4'd2, 1'b0, 3, 1'b0, -1, 0, 1'b1);
    checks++; if (n_got != 4) begin errors++; $display("FAIL istart_lanes got %0d exp 4", n_got); end
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL istart_done_latency got %0d exp 7", done_cyc); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== model(4'd2, 1'b0, k)) begin
        errors++; $display("FAIL istart_lane%0d got %h exp %h", k, got[k], model(4'd2, 1'b0, k));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp_c[4];
    bit saw_done;
    exp_c = '{64'd4, 64'd3, 64'd2, 64'd1};
    cfg_weight_width = 4'd2; cfg_signed = 1'b0; cfg_len = LEN_W'(1);
    start = 1'b1;
    step();
    start = 1'b0; psum_valid = 1'b1; psum_data = rnd52();
    step();
    psum_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd1) begin errors++; $display("FAIL rmid_on_lane1 got v%b lane%0d exp v1 lane1", out_valid, out_lane); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_lane !== 2'd0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || psum_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs_zero got v%b d%h l%0d last%b busy%b done%b rdy%b exp all 0",
                         out_valid, out_data, out_lane, out_last, busy, done, psum_ready);
    end
    saw_done = 1'b0;
    repeat (5) begin
      step();
      if (done) saw_done = 1'b1;
    end
    out_ready = 1'b0;
    checks++; if (saw_done) begin errors++; $display("FAIL rmid_no_done got pulse exp none"); end
    beats.delete();
    beats.push_back({13'd1, 13'd2, 13'd3, 13'd4});
    run_job(4'd2, 1'b0, 1, 1'b0, -1, 0, 1'b0);
    checks++; if (n_got != 4) begin errors++; $display("FAIL rmid_next_lanes got %0d exp 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== exp_c[k]) begin errors++; $display("FAIL rmid_next_lane%0d got %0d exp %0d", k, got[k], exp_c[k]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    test_reset();
    test_unsigned4();
    test_sign_ext();
    test_one_lane();
    test_random();
    test_stall();
    test_zero_len();
    test_ignored_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fusion_psum_drain.md
# fusion_psum_drain

Consumer end of the fusion-unit partial-sum interface. It sits at the bottom of a fusion-unit column and accepts the 52-bit packed `psum_fwd` word through a valid/ready handshake. It splits the word into lanes according to the weight width, sign- or zero-extends each lane, and accumulates a programmed number of beats. It then streams the lane totals out one per cycle to the output buffer.

## Interface
- `ACC_W`, 64: width of each lane accumulator and of `out_data`.
- `LEN_W`, 16: width of the beat-count field `cfg_len`.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse; latches `cfg_*` in IDLE; ignored in any other state.
- `cfg_weight_width`  in  4: 2 → 4 lanes of 13 bits; 4 → 2 lanes of 26 bits; 8 or any other value → 1 lane of 52 bits.
- `cfg_signed`  in  1: 1 = lanes are two's complement (`s_in|s_weight` of the array); 0 = unsigned.
- `cfg_len`  in  LEN_W: number of psum beats to accumulate.
- `psum_valid`  in  1: `psum_data` is valid.
- `psum_ready`  out  1: drain accepts a beat; high exactly when the state is ACCUM.
- `psum_data`  in  52: packed psum; lane k occupies bits [(k+1)·L−1 : k·L].
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  ACC_W: current lane accumulator.
- `out_lane`  out  2: index of the current lane.
- `out_last`  out  1: high with the final lane of the job.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse after the final lane is accepted.

## Operation
- States are IDLE, ACCUM and DRAIN.
- **IDLE**
  - On `start`, latch the lane count N (4/2/1), the lane width L (13/26/52), signedness and `cfg_len`.
  - Clear all four accumulators.
  - Go to ACCUM, or go to DRAIN if `cfg_len`==0; the latter emits N zero lanes.
- **ACCUM**
  - Each beat with `psum_valid & psum_ready`: acc[k] += ext(lane k), for k < N.
  - ext is sign-extension when signed, zero-extension otherwise.
  - Sums wrap modulo 2^ACC_W; there is no saturation.
  - The beat counter increments. Accepting beat number `cfg_len` moves to DRAIN.
  - Lanes k ≥ N are ignored and their accumulators stay 0.
- **DRAIN**
  - Lane index starts at 0; `out_valid`=1 and `out_data`=acc[idx].
  - `out_last` = (idx == N−1).
  - On `out_valid & out_ready`: increment idx.
  - When the last lane is accepted: go to IDLE and pulse `done` the next cycle.
- Config inputs are sampled only on `start`. Changes at any other time have no effect.
- `psum_valid` outside ACCUM is ignored.
- Reset at any time returns to IDLE on the next edge and discards partial sums.

## Timing
- **Reset values:** `psum_ready`=0, `out_valid`=0, `out_data`=0, `out_lane`=0, `out_last`=0, `busy`=0, `done`=0. Accumulators and counters are 0.
- `start` at edge t: `busy` and `psum_ready` are high from t+1.
- **Beat acceptance:** the beat accepted at edge t is reflected in the accumulators after t.
- **Entering DRAIN:** the last beat is accepted at edge t. `psum_ready`=0 and `out_valid`=1 from t+1, carrying the totals that include that beat.
- **Throughput:** 1 beat per cycle in ACCUM; 1 lane per cycle in DRAIN when `out_ready` is held high.
- **Job latency:** for `cfg_len`=K with no stalls, `done` pulses at start+K+N+1.
- `out_data`, `out_lane` and `out_last` hold stable while `out_valid & !out_ready`.
- All outputs are registered except `psum_ready`, which is decoded directly from the state register.
- `start` in the same cycle as `rst`: `rst` wins.

## Test plan
- **4-lane unsigned accumulate:** ww=2, unsigned, len=2, two beats {13'd9,13'd6,13'd3,13'd0} (lane3..lane0) → lanes 0..3 output 0, 6, 12, 18; `out_last` on lane 3; `done` one cycle later.
- **Signed vs unsigned extension:** ww=4, len=3, three beats with lane0=26'h3FFFFFF, lane1=26'd24.
  - Signed → lane0 = 64'hFFFF_FFFF_FFFF_FFFD (−3), lane1 = 72.
  - Unsigned → lane0 = 64'h0BFF_FFFD, lane1 = 72.
- **1-lane mode and odd width:** ww=8, len=4, beats 52'd65025 each → a single lane, 260100, with `out_last`=1. Repeat with ww=3 → identical result.
- **Backpressure and flow stalls:**
  - `psum_valid` toggles 1/0 in ACCUM; `out_ready` is low for 3 cycles on lane 1 in DRAIN.
  - Required: no beat lost or double-counted.
  - Required: `out_data` and `out_lane` are stable during the stall.
  - Required: totals match the no-stall run.
- **Zero length and ignored start:** `cfg_len`=0, ww=2 → 4 zero lanes, no `psum_ready` assertion. A `start` pulsed during ACCUM does not restart the job or relatch config.
- **Reset mid-operation:** `rst` on the second DRAIN lane → all outputs are 0 next cycle, no `done` pulse. A following job with ww=2, len=1, beat {13'd1,13'd2,13'd3,13'd4} outputs 4, 3, 2, 1, showing no stale sums.
